// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register whose outputs also act as the EX/MEM forwarding source.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        branch,
  input  logic        memread,
  input  logic        memtoreg,
  input  logic        memwrite,
  input  logic        alusrc,
  input  logic        regwrite,
  input  logic [1:0]  aluop,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] pc_in,
  input  logic [31:0] imm,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_wdata,
  output logic        branch_taken_EX_MEM,
  output logic [31:0] branch_target_EX_MEM,
  output logic        memread_EX_MEM,
  output logic        memtoreg_EX_MEM,
  output logic        memwrite_EX_MEM,
  output logic        regwrite_EX_MEM,
  output logic [31:0] alu_result_EX_MEM,
  output logic [31:0] store_data_EX_MEM,
  output logic [2:0]  funct3_EX_MEM,
  output logic [4:0]  rd_EX_MEM
);

  function automatic logic [31:0] alu_eval(input logic [1:0]  op,
                                           input logic [2:0]  f3,
                                           input logic        f7,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic        [4:0]  sh;
    logic        [31:0] res;
    sa  = a;
    sb  = b;
    sh  = b[4:0];
    res = a + b;
    if (op[1]) begin
      unique case (f3)
        3'b000: res = (!op[0] && f7) ? a - b : a + b;
        3'b001: res = a << sh;
        3'b010: res = {31'd0, sa < sb};
        3'b011: res = {31'd0, a < b};
        3'b100: res = a ^ b;
        3'b101: begin
          // Kept as separate statements so the arithmetic shift stays signed.
          if (f7) res = sa >>> sh;
          else    res = a >> sh;
        end
        3'b110: res = a | b;
        default: res = a & b;
      endcase
    end
    return res;
  endfunction

  function automatic logic branch_cond(input logic [2:0]  f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               c;
    sa = a;
    sb = b;
    unique case (f3)
      3'b000:  c = (a == b);
      3'b001:  c = (a != b);
      3'b100:  c = (sa < sb);
      3'b101:  c = (sa >= sb);
      3'b110:  c = (a < b);
      3'b111:  c = (a >= b);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic        r_branch_taken_p1;
  logic [31:0] r_branch_target_p1;
  logic        r_memread_p1;
  logic        r_memtoreg_p1;
  logic        r_memwrite_p1;
  logic        r_regwrite_p1;
  logic [31:0] r_alu_result_p1;
  logic [31:0] r_store_data_p1;
  logic [2:0]  r_funct3_p1;
  logic [4:0]  r_rd_p1;

  logic        w_exmem_hit_a_p0;
  logic        w_exmem_hit_b_p0;
  logic        w_memwb_hit_a_p0;
  logic        w_memwb_hit_b_p0;
  logic [31:0] w_fwd_a_p0;
  logic [31:0] w_fwd_b_p0;
  logic [31:0] w_alu_b_p0;
  logic [31:0] w_alu_res_p0;
  logic        w_taken_p0;

  // Stage p0: forwarding, ALU and branch resolution
  assign w_exmem_hit_a_p0 = r_regwrite_p1 && (r_rd_p1 != 5'd0) && (r_rd_p1 == rs1);
  assign w_exmem_hit_b_p0 = r_regwrite_p1 && (r_rd_p1 != 5'd0) && (r_rd_p1 == rs2);
  assign w_memwb_hit_a_p0 = memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs1);
  assign w_memwb_hit_b_p0 = memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs2);

  assign w_fwd_a_p0 = w_exmem_hit_a_p0 ? r_alu_result_p1 :
                      w_memwb_hit_a_p0 ? memwb_wdata     : read_data1;
  assign w_fwd_b_p0 = w_exmem_hit_b_p0 ? r_alu_result_p1 :
                      w_memwb_hit_b_p0 ? memwb_wdata     : read_data2;

  assign w_alu_b_p0   = alusrc ? imm : w_fwd_b_p0;
  assign w_alu_res_p0 = alu_eval(aluop, funct3, funct7, w_fwd_a_p0, w_alu_b_p0);
  assign w_taken_p0   = branch && branch_cond(funct3, w_fwd_a_p0, w_fwd_b_p0);

  // Stage p1: EX/MEM register; flush squashes only the side-effecting controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_taken_p1  <= 1'b0;
      r_branch_target_p1 <= 32'd0;
      r_memread_p1       <= 1'b0;
      r_memtoreg_p1      <= 1'b0;
      r_memwrite_p1      <= 1'b0;
      r_regwrite_p1      <= 1'b0;
      r_alu_result_p1    <= 32'd0;
      r_store_data_p1    <= 32'd0;
      r_funct3_p1        <= 3'd0;
      r_rd_p1            <= 5'd0;
    end else begin
      r_branch_taken_p1  <= w_taken_p0 & ~flush;
      r_branch_target_p1 <= pc_in + imm;
      r_memread_p1       <= memread  & ~flush;
      r_memtoreg_p1      <= memtoreg & ~flush;
      r_memwrite_p1      <= memwrite & ~flush;
      r_regwrite_p1      <= regwrite & ~flush;
      r_alu_result_p1    <= w_alu_res_p0;
      r_store_data_p1    <= w_fwd_b_p0;
      r_funct3_p1        <= funct3;
      r_rd_p1            <= rd;
    end
  end

  assign branch_taken_EX_MEM  = r_branch_taken_p1;
  assign branch_target_EX_MEM = r_branch_target_p1;
  assign memread_EX_MEM       = r_memread_p1;
  assign memtoreg_EX_MEM      = r_memtoreg_p1;
  assign memwrite_EX_MEM      = r_memwrite_p1;
  assign regwrite_EX_MEM      = r_regwrite_p1;
  assign alu_result_EX_MEM    = r_alu_result_p1;
  assign store_data_EX_MEM    = r_store_data_p1;
  assign funct3_EX_MEM        = r_funct3_p1;
  assign rd_EX_MEM            = r_rd_p1;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32I pipeline, sitting directly downstream of the ID/EX pipeline register and feeding the memory stage. It performs forwarding-operand selection, ALU evaluation, branch comparison and target calculation. It then registers all results and the surviving control bits into an internal EX/MEM pipeline register, and its own registered outputs serve as the EX/MEM forwarding source.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears the EX/MEM register
- flush  in  1  squash the instruction currently in EX (registers a bubble)
- branch, memread, memtoreg, memwrite, alusrc, regwrite  in  1 each  control bits from ID/EX
- aluop  in  2  00 add (load/store address), 01 branch compare, 10 R-type, 11 I-type ALU
- read_data1, read_data2  in  32  register-file operands from ID/EX
- pc_in  in  32  PC of the instruction in EX
- imm  in  32  sign-extended immediate
- funct3  in  3  instruction funct3
- funct7  in  1  instruction bit 30
- rd, rs1, rs2  in  5 each  register indices from ID/EX
- memwb_regwrite  in  1  write-back enable of the instruction in WB
- memwb_rd  in  5  destination of the instruction in WB
- memwb_wdata  in  32  write-back data of the instruction in WB
- branch_taken_EX_MEM  out  1  registered branch decision
- branch_target_EX_MEM  out  32  registered pc_in + imm
- memread_EX_MEM, memtoreg_EX_MEM, memwrite_EX_MEM, regwrite_EX_MEM  out  1 each
- alu_result_EX_MEM  out  32  registered ALU result / memory address
- store_data_EX_MEM  out  32  registered forwarded rs2 value
- funct3_EX_MEM  out  3  access size for the memory stage
- rd_EX_MEM  out  5  registered destination index

## Operation
- Forwarding, operand A (same for B with rs2):
  - if regwrite_EX_MEM and rd_EX_MEM != 0 and rd_EX_MEM == rs1, take alu_result_EX_MEM;
  - else if memwb_regwrite and memwb_rd != 0 and memwb_rd == rs1, take memwb_wdata;
  - else take read_data1.
- EX/MEM has priority over MEM/WB. Register index 0 never forwards.
- fwdB is the forwarded rs2 value. It always becomes store_data. The ALU's second operand is imm when alusrc=1, else fwdB.
- ALU function:
  - aluop 00: A + B.
  - aluop 01: A + B; result unused except as a don't-care.
  - aluop 10 and 11, by funct3:
    - 000 add, or sub when aluop=10 and funct7=1
    - 001 sll
    - 010 slt (signed)
    - 011 sltu
    - 100 xor
    - 101 srl when funct7=0, sra when funct7=1
    - 110 or
    - 111 and
- Shift amount is B[4:0]. All arithmetic is modulo 2^32 with no overflow flag.
- Branch compare is on fwdA versus fwdB when branch=1, by funct3:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 are never taken.
  - taken = branch AND condition.
- branch_target = pc_in + imm, wrapping modulo 2^32.
- Flush: when flush=1 at a rising edge, branch_taken, memread, memwrite, regwrite and memtoreg are registered as 0. Data fields still register normally and are don't-care.
- There is no stall input. A bubble is injected upstream by zeroing the ID/EX control bits.

## Timing
- Reset values: every output is 0 (all control bits 0, all data 0, rd 0). Reset is asynchronous, so outputs drop to 0 immediately. Reset mid-stream discards the instruction in EX.
- Latency is one cycle: inputs present before edge N appear on the EX/MEM outputs after edge N.
- Forwarding is combinational from the current EX/MEM outputs and the memwb_* inputs. Back-to-back dependent ALU instructions therefore need no stall.
- Load-use hazards are not resolved here. The hazard unit in ID inserts the bubble.
- If flush and a taken branch occur in the same cycle, flush wins and the registered branch_taken is 0.
- Simultaneous EX/MEM and MEM/WB matches on the same index select EX/MEM.
- Asserting regwrite with rd=0 registers normally; downstream ignores writes to x0.

## Test plan
- Reset: assert reset mid-cycle with nonzero inputs -> all outputs 0 immediately; they stay 0 until the first edge after release.
- R-type: A=7, B=10, aluop=10, funct3=000, funct7=1 -> alu_result=0xFFFFFFFD next cycle. Same inputs with funct3=101, funct7=1, A=0x80000000, B=4 -> 0xF8000000.
- Forward priority: EX/MEM holds rd=5, result=0x11, regwrite=1; memwb_rd=5, wdata=0x22; rs1=5, read_data1=0x33, B=1 add -> result 0x12. With rs1=0 instead -> read_data1 used.
- Branch: pc_in=0x100, imm=0xFFFFFFF0 (-16), fwdA=0xFFFFFFFF, fwdB=1, funct3=100 -> taken=1, target=0xF0. funct3=110 -> taken=0.
- Flush: taken beq with regwrite=1 and flush=1 -> branch_taken, regwrite, memwrite, memread and memtoreg all 0 next cycle.
- Store forwarding: sw with rs2 matching memwb_rd=3, wdata=0xDEADBEEF, alusrc=1, imm=8, A=0x1000 -> store_data=0xDEADBEEF, alu_result=0x1008, memwrite=1.
